pc_sequencer: RTL

- Next-PC controller for the fetch stage; drives the fetch stage's 32-bit PC input every cycle.
- Arbitrates sequential fetch, load-use stall, jump (ID), branch/jr redirect (EX), synchronous exception, external interrupt and exception return.
- Generates pipeline flush strobes and tracks user/kernel mode with an EPC register.
- Sits between the hazard/branch logic and the fetch stage; keeps a shadow of the fetch stage's PC register.

---
 rtl/pc_sequencer_pkg.sv | 25 ++
 rtl/pc_sequencer_sel_prio.sv | 46 ++++
 rtl/pc_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the next-PC sequencer.
// Mode encoding, select codes and default vector addresses.
package pc_sequencer_pkg;

    typedef enum logic {
        MODE_USER   = 1'b0,
        MODE_KERNEL = 1'b1
    } mode_t;

    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_ERET,
        SEL_REDIR,
        SEL_IRQ,
        SEL_HOLD,
        SEL_JUMP,
        SEL_SEQ
    } sel_t;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;
    localparam logic [31:0] DEF_IRQ_VECTOR = 32'h8000_0200;
    localparam logic [31:0] PC_STEP        = 32'd4;

endpackage

// File: rtl/pc_sequencer_sel_prio.sv
// Priority encoder from pipeline events to the next-PC select code.
// Purely combinational; earlier tests in the chain win.
module pc_sel_prio
    import pc_sequencer_pkg::*;
(
    input  logic i_exception,
    input  logic i_eret,
    input  logic i_redirect,
    input  logic i_irq_pend,
    input  logic i_kernel,
    input  logic i_stall,
    input  logic i_jump,
    output sel_t o_sel,
    output logic o_flush_if_id,
    output logic o_flush_id_ex
);

    always_comb begin
        o_sel         = SEL_SEQ;
        o_flush_if_id = 1'b0;
        o_flush_id_ex = 1'b0;
        if (i_exception) begin
            o_sel         = SEL_EXC;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
        end else if (i_eret && i_kernel) begin
            o_sel         = SEL_ERET;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
        end else if (i_redirect) begin
            o_sel         = SEL_REDIR;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
        end else if (i_irq_pend && !i_kernel && !i_stall) begin
            // ID/EX holds a valid older instruction; only IF/ID is squashed
            o_sel         = SEL_IRQ;
            o_flush_if_id = 1'b1;
        end else if (i_stall) begin
            o_sel = SEL_HOLD;
        end else if (i_jump) begin
            o_sel         = SEL_JUMP;
            o_flush_if_id = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for fetch: target mux, PC shadow, EPC,
// user/kernel mode and latched interrupt request.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter logic [31:0] IRQ_VECTOR = DEF_IRQ_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        exception,
    input  logic [31:0] exc_pc,
    input  logic        irq,
    input  logic        eret,
    output logic [31:0] pc_next,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] epc,
    output logic        kernel
);

    logic [31:0] r_pc_cur;
    logic [31:0] r_epc;
    mode_t       r_mode;
    logic        r_irq_pend;

    sel_t w_prio_sel;
    sel_t w_sel;
    logic w_prio_fif;
    logic w_prio_fie;
    logic w_kernel;

    assign w_kernel = (r_mode == MODE_KERNEL);

    pc_sel_prio u_prio (
        .i_exception   (exception),
        .i_eret        (eret),
        .i_redirect    (redirect),
        .i_irq_pend    (r_irq_pend),
        .i_kernel      (w_kernel),
        .i_stall       (stall),
        .i_jump        (jump),
        .o_sel         (w_prio_sel),
        .o_flush_if_id (w_prio_fif),
        .o_flush_id_ex (w_prio_fie)
    );

    // While reset is high, fetch sees the plain step from RESET_PC
    assign w_sel       = reset ? SEL_SEQ : w_prio_sel;
    assign flush_if_id = w_prio_fif & ~reset;
    assign flush_id_ex = w_prio_fie & ~reset;
    assign epc         = r_epc;
    assign kernel      = w_kernel;

    always_comb begin
        pc_next = r_pc_cur + PC_STEP;
        unique case (w_sel)
            SEL_EXC:   pc_next = EXC_VECTOR;
            SEL_ERET:  pc_next = r_epc;
            SEL_REDIR: pc_next = redirect_target;
            SEL_IRQ:   pc_next = IRQ_VECTOR;
            SEL_HOLD:  pc_next = r_pc_cur;
            SEL_JUMP:  pc_next = jump_target;
            SEL_SEQ:   pc_next = r_pc_cur + PC_STEP;
            default:   pc_next = r_pc_cur + PC_STEP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_cur   <= RESET_PC;
            r_epc      <= '0;
            r_mode     <= MODE_USER;
            r_irq_pend <= 1'b0;
        end else begin
            r_pc_cur <= pc_next;
            if (w_sel == SEL_EXC) begin
                r_epc  <= exc_pc;
                r_mode <= MODE_KERNEL;
            end else if (w_sel == SEL_IRQ) begin
                r_epc  <= r_pc_cur;
                r_mode <= MODE_KERNEL;
            end else if (w_sel == SEL_ERET) begin
                r_mode <= MODE_USER;
            end
            if (w_sel == SEL_IRQ)
                r_irq_pend <= 1'b0;
            else if (irq && !w_kernel)
                r_irq_pend <= 1'b1;
        end
    end

endmodule
